// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M multiply/divide unit with a shared shift-add / restoring-subtract datapath.
// Optional MULDIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow bypass CALC.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             busy,
    output logic             ready,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ZERO = '0;

    typedef enum logic [1:0] {IDLE, CALC, FIX, OUT} state_t;

    state_t state_q, state_d;

    logic [2:0]         op_q;
    logic [WIDTH-1:0]   a_mag_q, b_mag_q;
    logic               neg_res_q, neg_rem_q;
    logic               div_zero_q, ovf_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] acc_q;

    logic               a_signed, b_signed, a_neg, b_neg;
    logic               div_zero, ovf, special, accept;
    logic [WIDTH-1:0]   a_mag, b_mag;

    always_comb begin
        a_signed = op[2] ? ~op[0] : ~(op[1] & op[0]);
        b_signed = op[2] ? ~op[0] : ~op[1];
        a_neg    = a_signed & in_a[WIDTH-1];
        b_neg    = b_signed & in_b[WIDTH-1];
        a_mag    = a_neg ? -in_a : in_a;
        b_mag    = b_neg ? -in_b : in_b;
        div_zero = (in_b == ZERO);
        ovf      = op[2] & ~op[0] & (in_a == MIN) & (in_b == ~ZERO);
`ifdef MULDIV_FAST_SPECIAL_EN
        special  = op[2] & (div_zero | ovf);
`else
        special  = 1'b0;
`endif
        accept   = (state_q == IDLE) & valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (valid) state_d = special ? FIX : CALC;
            CALC: if (cnt_q == LAST) state_d = FIX;
            FIX:  state_d = OUT;
            OUT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // One iteration: multiply adds into the high half and shifts right;
    // divide shifts left and subtracts when the partial remainder allows.
    logic [WIDTH:0]     msum, cand;
    logic [WIDTH-1:0]   diff;
    logic               qbit;
    logic [2*WIDTH-1:0] acc_step;

    always_comb begin
        msum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
             + {1'b0, (acc_q[0] ? a_mag_q : ZERO)};
        cand = acc_q[2*WIDTH-1:WIDTH-1];
        diff = cand[WIDTH-1:0] - b_mag_q;
        qbit = (cand >= {1'b0, b_mag_q});
        if (op_q[2])
            acc_step = {(qbit ? diff : cand[WIDTH-1:0]),
                        acc_q[WIDTH-2:0], qbit};
        else
            acc_step = {msum, acc_q[WIDTH-1:1]};
    end

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo_s, rem_s, a_orig, fix_val;
    logic               mul_lo, mul_hi, is_div, is_rem;

    always_comb begin
        prod    = neg_res_q ? -acc_q : acc_q;
        quo_s   = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_s   = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH]
                            : acc_q[2*WIDTH-1:WIDTH];
        a_orig  = neg_rem_q ? -a_mag_q : a_mag_q;
        mul_lo  = (op_q == 3'b000);
        mul_hi  = ~op_q[2] & (op_q[1:0] != 2'b00);
        is_div  = op_q[2] & ~op_q[1];
        is_rem  = op_q[2] & op_q[1];
        fix_val = ZERO;
        unique case (1'b1)
            mul_lo: fix_val = prod[WIDTH-1:0];
            mul_hi: fix_val = prod[2*WIDTH-1:WIDTH];
            is_div: fix_val = div_zero_q ? ~ZERO
                            : ovf_q      ? MIN : quo_s;
            is_rem: fix_val = div_zero_q ? a_orig
                            : ovf_q      ? ZERO : rem_s;
            default: fix_val = ZERO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= 3'b000;
            a_mag_q    <= ZERO;
            b_mag_q    <= ZERO;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
            cnt_q      <= '0;
            acc_q      <= '0;
            result     <= ZERO;
        end else begin
            if (accept) begin
                op_q       <= op;
                a_mag_q    <= a_mag;
                b_mag_q    <= b_mag;
                neg_res_q  <= a_neg ^ b_neg;
                neg_rem_q  <= a_neg;
                div_zero_q <= div_zero;
                ovf_q      <= ovf;
                cnt_q      <= '0;
                acc_q      <= {ZERO, (op[2] ? a_mag : b_mag)};
            end else if (state_q == CALC) begin
                acc_q <= acc_step;
                if (cnt_q != LAST) cnt_q <= cnt_q + CW'(1);
            end
            if (state_q == FIX) result <= fix_val;
        end
    end

    assign busy  = (state_q != IDLE);
    assign ready = (state_q == OUT);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: WIDTH=32 scenarios plus a WIDTH=8
// sweep over corner operands against a behavioural model.
module tb_muldiv_unit;

`ifdef MULDIV_FAST_SPECIAL_EN
    localparam int SPEC32 = 2;
    localparam int SPEC8  = 2;
`else
    localparam int SPEC32 = 34;
    localparam int SPEC8  = 10;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] in_a = '0, in_b = '0;
    logic        busy, ready;
    logic [31:0] result;

    logic        valid8 = 1'b0;
    logic [2:0]  op8 = 3'b000;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, ready8;
    logic [7:0]  res8;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .valid(valid), .op(op),
        .in_a(in_a), .in_b(in_b), .busy(busy), .ready(ready),
        .result(result)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .valid(valid8), .op(op8),
        .in_a(a8), .in_b(b8), .busy(busy8), .ready(ready8),
        .result(res8)
    );

    task automatic run32(input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] r,
                         output int lat);
        @(negedge clk);
        valid = 1'b1; op = o; in_a = a; in_b = b;
        @(posedge clk);
        lat = -1;
        r = '0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 1) begin
                valid = 1'b0;
                op = 3'($urandom);
                in_a = $urandom;
                in_b = $urandom;
            end
            if (ready) begin
                lat = c;
                r = result;
                break;
            end
        end
    endtask

    task automatic run8(input logic [2:0] o, input logic [7:0] a,
                        input logic [7:0] b, output logic [7:0] r,
                        output int lat);
        @(negedge clk);
        valid8 = 1'b1; op8 = o; a8 = a; b8 = b;
        @(posedge clk);
        lat = -1;
        r = '0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) begin
                valid8 = 1'b0;
                a8 = ~a;
                b8 = ~b;
            end
            if (ready8) begin
                lat = c;
                r = res8;
                break;
            end
        end
    endtask

    function automatic logic [7:0] model8(input logic [2:0] o,
                                          input logic [7:0] a,
                                          input logic [7:0] b);
        int sa, sb, ua, ub, p;
        sa = int'($signed(a));
        sb = int'($signed(b));
        ua = int'(a);
        ub = int'(b);
        p = 0;
        case (o)
            3'd0: p = sa * sb;
            3'd1: p = (sa * sb) >>> 8;
            3'd2: p = (sa * ub) >>> 8;
            3'd3: p = (ua * ub) >> 8;
            3'd4: begin
                if (b == 8'h00) p = -1;
                else if (a == 8'h80 && b == 8'hFF) p = -128;
                else p = sa / sb;
            end
            3'd5: begin
                if (b == 8'h00) p = 255;
                else p = ua / ub;
            end
            3'd6: begin
                if (b == 8'h00) p = ua;
                else if (a == 8'h80 && b == 8'hFF) p = 0;
                else p = sa % sb;
            end
            default: begin
                if (b == 8'h00) p = ua;
                else p = ua % ub;
            end
        endcase
        return p[7:0];
    endfunction

    task automatic test_reset();
        #1;
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        tests++;
        if (ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready: got %b want 0", ready);
        end
        tests++;
        if (result !== 32'h0) begin
            fails++;
            $display("FAIL reset_result: got %h want 0", result);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_mul_timing();
        logic exp_b, exp_r;
        @(negedge clk);
        valid = 1'b1; op = 3'b000;
        in_a = 32'd7; in_b = 32'hFFFF_FFFD;
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL busy_c0: got %b want 0", busy);
        end
        for (int c = 1; c <= 36; c++) begin
            @(negedge clk);
            if (c == 1) valid = 1'b0;
            exp_b = (c <= 34);
            exp_r = (c == 34);
            tests++;
            if (busy !== exp_b) begin
                fails++;
                $display("FAIL busy_c%0d: got %b want %b", c, busy, exp_b);
            end
            tests++;
            if (ready !== exp_r) begin
                fails++;
                $display("FAIL ready_c%0d: got %b want %b", c, ready, exp_r);
            end
            if (c == 34) begin
                tests++;
                if (result !== 32'hFFFF_FFEB) begin
                    fails++;
                    $display("FAIL mul_result: got %h want ffffffeb",
                             result);
                end
            end
        end
    endtask

    task automatic test_ops32();
        logic [2:0]  o [12] = '{3'b001, 3'b011, 3'b010, 3'b100,
                                3'b110, 3'b101, 3'b111, 3'b100,
                                3'b110, 3'b100, 3'b110, 3'b000};
        logic [31:0] a [12] = '{32'h8000_0000, 32'hFFFF_FFFF,
                                32'hFFFF_FFFF, 32'hFFFF_FFF9,
                                32'hFFFF_FFF9, 32'd100, 32'd100,
                                32'hFFFF_FFFB, 32'hFFFF_FFFB,
                                32'h8000_0000, 32'h8000_0000,
                                32'h1234_5678};
        logic [31:0] b [12] = '{32'h8000_0000, 32'hFFFF_FFFF,
                                32'hFFFF_FFFF, 32'd2, 32'd2, 32'd7,
                                32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF,
                                32'hFFFF_FFFF, 32'd16};
        logic [31:0] e [12] = '{32'h4000_0000, 32'hFFFF_FFFE,
                                32'hFFFF_FFFF, 32'hFFFF_FFFD,
                                32'hFFFF_FFFF, 32'd14, 32'd2,
                                32'hFFFF_FFFF, 32'hFFFF_FFFB,
                                32'h8000_0000, 32'h0, 32'h2345_6780};
        int          l [12] = '{34, 34, 34, 34, 34, 34, 34,
                                SPEC32, SPEC32, SPEC32, SPEC32, 34};
        logic [31:0] r;
        int          lat;
        for (int i = 0; i < 12; i++) begin
            run32(o[i], a[i], b[i], r, lat);
            tests++;
            if (r !== e[i]) begin
                fails++;
                $display("FAIL op32_%0d_result: got %h want %h",
                         i, r, e[i]);
            end
            tests++;
            if (lat != l[i]) begin
                fails++;
                $display("FAIL op32_%0d_latency: got %0d want %0d",
                         i, lat, l[i]);
            end
        end
    endtask

    task automatic test_valid_while_busy();
        int          first = -1, second = -1, pulses = 0;
        logic [31:0] r1 = '0, r2 = '0;
        @(negedge clk);
        valid = 1'b1; op = 3'b101; in_a = 32'd100; in_b = 32'd7;
        for (int c = 1; c <= 75; c++) begin
            @(negedge clk);
            if (c <= 34) begin
                op = 3'($urandom);
                in_a = $urandom;
                in_b = $urandom;
            end else if (c == 35) begin
                op = 3'b000; in_a = 32'd5; in_b = 32'd6;
            end else begin
                valid = 1'b0;
            end
            if (c == 35) begin
                tests++;
                if (busy !== 1'b0) begin
                    fails++;
                    $display("FAIL vwb_idle_busy: got %b want 0", busy);
                end
            end
            if (c == 36) begin
                tests++;
                if (busy !== 1'b1) begin
                    fails++;
                    $display("FAIL vwb_accept_busy: got %b want 1", busy);
                end
            end
            if (ready) begin
                pulses++;
                if (first < 0) begin
                    first = c; r1 = result;
                end else begin
                    second = c; r2 = result;
                end
            end
        end
        tests++;
        if (first != 34 || r1 !== 32'd14) begin
            fails++;
            $display("FAIL vwb_first: got c%0d %h want c34 0000000e",
                     first, r1);
        end
        tests++;
        if (second != 69 || r2 !== 32'd30) begin
            fails++;
            $display("FAIL vwb_second: got c%0d %h want c69 0000001e",
                     second, r2);
        end
        tests++;
        if (pulses != 2) begin
            fails++;
            $display("FAIL vwb_pulses: got %0d want 2", pulses);
        end
    endtask

    task automatic test_reset_mid();
        int          pulses = 0;
        logic [31:0] r;
        int          lat;
        @(negedge clk);
        valid = 1'b1; op = 3'b101; in_a = 32'd1000; in_b = 32'd3;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) valid = 1'b0;
            if (ready) pulses++;
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (busy !== 1'b0 || ready !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_flags: got busy=%b ready=%b want 0 0",
                     busy, ready);
        end
        tests++;
        if (result !== 32'h0) begin
            fails++;
            $display("FAIL rstmid_result: got %h want 0", result);
        end
        @(negedge clk);
        tests++;
        if (ready !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_hold_ready: got %b want 0", ready);
        end
        rst_n = 1'b1;
        tests++;
        if (pulses != 0) begin
            fails++;
            $display("FAIL rstmid_pulses: got %0d want 0", pulses);
        end
        run32(3'b011, 32'd3, 32'd5, r, lat);
        tests++;
        if (r !== 32'h0 || lat != 34) begin
            fails++;
            $display("FAIL rstmid_mulhu: got %h c%0d want 0 c34", r, lat);
        end
    endtask

    task automatic test_w8_sweep();
        logic [7:0] v [14] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h07,
                               8'h10, 8'h55, 8'h7F, 8'h80, 8'h81,
                               8'hAA, 8'hF9, 8'hFE, 8'hFF};
        logic [7:0] r, e;
        logic [2:0] o;
        int         lat, el;
        logic       sp;
        for (int k = 0; k < 8; k++) begin
            o = 3'(k);
            for (int i = 0; i < 14; i++) begin
                for (int j = 0; j < 14; j++) begin
                    run8(o, v[i], v[j], r, lat);
                    e = model8(o, v[i], v[j]);
                    sp = o[2] && (v[j] == 8'h00 ||
                         (!o[0] && v[i] == 8'h80 && v[j] == 8'hFF));
                    el = sp ? SPEC8 : 10;
                    tests++;
                    if (r !== e) begin
                        fails++;
                        $display("FAIL w8_op%0d_%h_%h: got %h want %h",
                                 k, v[i], v[j], r, e);
                    end
                    tests++;
                    if (lat != el) begin
                        fails++;
                        $display("FAIL w8_lat_op%0d_%h_%h: got %0d want %0d",
                                 k, v[i], v[j], lat, el);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul_timing();
        test_ops32();
        test_valid_while_busy();
        test_reset_mid();
        test_w8_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
